// File: rtl/pea_pkg.sv
// Shared PEA geometry, derived widths and the commit FSM state type.
package pea_pkg;

  localparam int N             = 4;
  localparam int M             = 4;
  localparam int N_CFG_REGS_PE = 4;
  localparam int DATA_W        = 32;

  localparam int N_PE     = N * M;
  localparam int LOG_N_PE = $clog2(N * M);

  localparam int SLOT_W  = N_CFG_REGS_PE * DATA_W;
  localparam int CFG_W   = N_PE * SLOT_W;
  localparam int CONST_W = N_PE * DATA_W;

  localparam logic [LOG_N_PE-1:0] IDX_LAST = LOG_N_PE'(N_PE - 1);

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_WAIT_IDLE,
    CS_COPY,
    CS_DONE
  } cfg_shadow_state_e;

endpackage

// File: rtl/pe_cfg_shadow_slot.sv
// Shadow copy of one PE: its configuration words plus its constant.
// Cleared by reset, loaded only when the commit sequencer selects this PE.
module pe_cfg_shadow_slot
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [SLOT_W-1:0] cfg_i,
  input  logic [DATA_W-1:0] const_i,
  output logic [SLOT_W-1:0] cfg_o,
  output logic [DATA_W-1:0] const_o
);

  // Shadow register: straight copy of the live words when selected, hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_o   <= '0;
      const_o <= '0;
    end else if (we_i) begin
      cfg_o   <= cfg_i;
      const_o <= const_i;
    end
  end

endmodule

// File: rtl/pea_cfg_shadow.sv
// Commit stage between the live peripheral registers and the PEA.
// On a commit request taken while the PEA is idle, the live configuration is
// copied into shadow registers one PE per cycle in row-major order.
// Optional build macro MAGE_CFG_SHADOW_CNT_EN adds commit_cnt_o, a 16-bit
// wrapping count of completed commits.
//
//  state        | meaning
//  -------------+---------------------------------------------------------
//  CS_IDLE      | waiting for commit_req_i; shadows hold
//  CS_WAIT_IDLE | request taken, waiting for the PEA to become idle
//  CS_COPY      | copying PE idx this cycle, idx advances each cycle
//  CS_DONE      | snapshot complete; done pulse, cfg_valid set at cycle end
module pea_cfg_shadow
  import pea_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               commit_req_i,
  input  logic               pea_idle_i,
  input  logic [CFG_W-1:0]   reg_cfg_pea_i,
  input  logic [CONST_W-1:0] reg_pea_constants_i,
  output logic               commit_busy_o,
  output logic               commit_done_o,
  output logic               cfg_valid_o,
  output logic [CFG_W-1:0]   shadow_cfg_pea_o,
  output logic [CONST_W-1:0] shadow_pea_constants_o
`ifdef MAGE_CFG_SHADOW_CNT_EN
  ,
  output logic [15:0]        commit_cnt_o
`endif
);

  cfg_shadow_state_e   state, state_nxt;
  logic [LOG_N_PE-1:0] idx, idx_nxt;
  logic [N_PE-1:0]     slot_we;

  // State, PE index and valid flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= CS_IDLE;
      idx         <= '0;
      cfg_valid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == CS_DONE) cfg_valid_o <= 1'b1;
    end
  end

  // Next-state logic and one-hot slot write enable from the registered index.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    slot_we   = '0;
    unique case (state)
      CS_IDLE: begin
        if (commit_req_i) state_nxt = pea_idle_i ? CS_COPY : CS_WAIT_IDLE;
      end
      CS_WAIT_IDLE: begin
        if (pea_idle_i) state_nxt = CS_COPY;
      end
      CS_COPY: begin
        slot_we[idx] = 1'b1;
        if (idx == IDX_LAST) begin
          state_nxt = CS_DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      CS_DONE: begin
        state_nxt = CS_IDLE;
      end
      default: state_nxt = CS_IDLE;
    endcase
  end

  assign commit_busy_o = (state != CS_IDLE);
  assign commit_done_o = (state == CS_DONE);

`ifdef MAGE_CFG_SHADOW_CNT_EN
  // Completed-commit counter; wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) commit_cnt_o <= '0;
    else if (state == CS_DONE) commit_cnt_o <= commit_cnt_o + 16'd1;
  end
`endif

  for (genvar p = 0; p < N_PE; p++) begin : g_slot
    pe_cfg_shadow_slot u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (slot_we[p]),
      .cfg_i   (reg_cfg_pea_i[p*SLOT_W +: SLOT_W]),
      .const_i (reg_pea_constants_i[p*DATA_W +: DATA_W]),
      .cfg_o   (shadow_cfg_pea_o[p*SLOT_W +: SLOT_W]),
      .const_o (shadow_pea_constants_o[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pea_cfg_shadow.sv
// Self-checking bench for pea_cfg_shadow: expected snapshots are queued when a
// commit is launched and compared word by word when the commit completes.
module tb_pea_cfg_shadow;
  import pea_pkg::*;

  localparam int NW = N_PE * N_CFG_REGS_PE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit_req = 1'b0;
  logic pea_idle = 1'b1;
  logic [DATA_W-1:0] live_cfg [NW];
  logic [DATA_W-1:0] live_const [N_PE];
  logic [CFG_W-1:0]   reg_cfg;
  logic [CONST_W-1:0] reg_const;

  logic               busy, done, valid;
  logic [CFG_W-1:0]   sh_cfg;
  logic [CONST_W-1:0] sh_const;
`ifdef MAGE_CFG_SHADOW_CNT_EN
  logic [15:0]        cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [CFG_W-1:0]   sb_cfg [$];
  logic [CONST_W-1:0] sb_const [$];
  logic [CFG_W-1:0]   last_cfg = '0;

  pea_cfg_shadow dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .commit_req_i           (commit_req),
    .pea_idle_i             (pea_idle),
    .reg_cfg_pea_i          (reg_cfg),
    .reg_pea_constants_i    (reg_const),
    .commit_busy_o          (busy),
    .commit_done_o          (done),
    .cfg_valid_o            (valid),
    .shadow_cfg_pea_o       (sh_cfg),
    .shadow_pea_constants_o (sh_const)
`ifdef MAGE_CFG_SHADOW_CNT_EN
    ,
    .commit_cnt_o           (cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    reg_cfg   = '0;
    reg_const = '0;
    for (int i = 0; i < NW; i++) reg_cfg[i*DATA_W +: DATA_W] = live_cfg[i];
    for (int i = 0; i < N_PE; i++) reg_const[i*DATA_W +: DATA_W] = live_const[i];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(input logic [31:0] base, input logic [31:0] cbase);
    for (int pe = 0; pe < N_PE; pe++) begin
      for (int k = 0; k < N_CFG_REGS_PE; k++)
        live_cfg[pe*N_CFG_REGS_PE + k] = base | 32'(((pe / M) << 8) | ((pe % M) << 4) | k);
      live_const[pe] = cbase + 32'(pe);
    end
  endtask

  task automatic push_expected();
    #0;
    sb_cfg.push_back(reg_cfg);
    sb_const.push_back(reg_const);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    commit_req = 1'b0;
    pea_idle = 1'b1;
    set_pattern(32'h1111_0000, 32'h11);
    step();
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_tests++; if (sh_cfg !== '0) begin n_fail++; $display("FAIL reset_shadow_cfg got %h want 0", sh_cfg); end
    n_tests++; if (sh_const !== '0) begin n_fail++; $display("FAIL reset_shadow_const got %h want 0", sh_const); end
`ifdef MAGE_CFG_SHADOW_CNT_EN
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", cnt); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_commit_idle();
    logic [CFG_W-1:0] ec;
    logic [CONST_W-1:0] ek;
    set_pattern(32'hA000_0000, 32'hC0);
    push_expected();
    commit_req = 1'b1;
    pea_idle = 1'b1;
    step();
    commit_req = 1'b0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_busy cyc%0d got %b want 1", cyc, busy); end
      n_tests++; if (done !== (cyc == 17)) begin n_fail++; $display("FAIL idle_done cyc%0d got %b want %b", cyc, done, cyc == 17); end
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid_early cyc%0d got %b want 0", cyc, valid); end
      step();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy_end got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done_end got %b want 0", done); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL idle_valid got %b want 1", valid); end
    n_tests++;
    if (sb_cfg.size() == 0) begin n_fail++; $display("FAIL idle_sb_empty got 0 entries want 1"); end
    else begin
      ec = sb_cfg.pop_front();
      ek = sb_const.pop_front();
      last_cfg = ec;
      for (int w = 0; w < NW; w++) begin
        n_tests++;
        if (sh_cfg[w*DATA_W +: DATA_W] !== ec[w*DATA_W +: DATA_W]) begin
          n_fail++; $display("FAIL idle_cfg w%0d got %h want %h", w, sh_cfg[w*DATA_W +: DATA_W], ec[w*DATA_W +: DATA_W]);
        end
      end
      for (int p = 0; p < N_PE; p++) begin
        n_tests++;
        if (sh_const[p*DATA_W +: DATA_W] !== ek[p*DATA_W +: DATA_W]) begin
          n_fail++; $display("FAIL idle_const pe%0d got %h want %h", p, sh_const[p*DATA_W +: DATA_W], ek[p*DATA_W +: DATA_W]);
        end
      end
    end
  endtask

  task automatic test_wait_idle();
    logic [CFG_W-1:0] ec;
    logic [CONST_W-1:0] ek;
    set_pattern(32'hB000_0000, 32'hD0);
    push_expected();
    pea_idle = 1'b0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy i%0d got %b want 1", i, busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL wait_done i%0d got %b want 0", i, done); end
      n_tests++; if (sh_cfg !== last_cfg) begin n_fail++; $display("FAIL wait_shadow_hold i%0d got %h want %h", i, sh_cfg, last_cfg); end
      step();
    end
    pea_idle = 1'b1;
    step();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_copy_busy cyc%0d got %b want 1", cyc, busy); end
      n_tests++; if (done !== (cyc == 17)) begin n_fail++; $display("FAIL wait_copy_done cyc%0d got %b want %b", cyc, done, cyc == 17); end
      step();
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_busy_end got %b want 0", busy); end
    n_tests++;
    if (sb_cfg.size() == 0) begin n_fail++; $display("FAIL wait_sb_empty got 0 entries want 1"); end
    else begin
      ec = sb_cfg.pop_front();
      ek = sb_const.pop_front();
      last_cfg = ec;
      for (int w = 0; w < NW; w++) begin
        n_tests++;
        if (sh_cfg[w*DATA_W +: DATA_W] !== ec[w*DATA_W +: DATA_W]) begin
          n_fail++; $display("FAIL wait_cfg w%0d got %h want %h", w, sh_cfg[w*DATA_W +: DATA_W], ec[w*DATA_W +: DATA_W]);
        end
      end
      n_tests++;
      if (sh_const !== ek) begin n_fail++; $display("FAIL wait_const got %h want %h", sh_const, ek); end
    end
  endtask

  task automatic test_write_during_copy();
    logic [CFG_W-1:0] ec;
    logic [CONST_W-1:0] ek;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_pattern(32'hA000_0000, 32'hC0);
      push_expected();
      commit_req = 1'b1;
      pea_idle = 1'b1;
      step();
      commit_req = 1'b0;
      for (int cyc = 1; cyc <= 17; cyc++) begin
        if (pass == 0 && cyc == 2) live_cfg[0] = 32'hDEAD_BEEF;
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL wdc_valid p%0d cyc%0d got %b want 1", pass, cyc, valid); end
        n_tests++; if (done !== (cyc == 17)) begin n_fail++; $display("FAIL wdc_done p%0d cyc%0d got %b want %b", pass, cyc, done, cyc == 17); end
        step();
      end
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL wdc_valid_end p%0d got %b want 1", pass, valid); end
      n_tests++;
      if (sb_cfg.size() == 0) begin n_fail++; $display("FAIL wdc_sb_empty p%0d got 0 entries want 1", pass); end
      else begin
        ec = sb_cfg.pop_front();
        ek = sb_const.pop_front();
        last_cfg = ec;
        for (int w = 0; w < NW; w++) begin
          n_tests++;
          if (sh_cfg[w*DATA_W +: DATA_W] !== ec[w*DATA_W +: DATA_W]) begin
            n_fail++; $display("FAIL wdc_cfg p%0d w%0d got %h want %h", pass, w, sh_cfg[w*DATA_W +: DATA_W], ec[w*DATA_W +: DATA_W]);
          end
        end
        n_tests++;
        if (sh_const !== ek) begin n_fail++; $display("FAIL wdc_const p%0d got %h want %h", pass, sh_const, ek); end
      end
    end
    n_tests++;
    if (sh_cfg[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wdc_word0 got %h want deadbeef", sh_cfg[31:0]); end
  endtask

  task automatic test_reset_mid_copy();
    set_pattern(32'h5000_0000, 32'h40);
    commit_req = 1'b1;
    pea_idle = 1'b1;
    step();
    commit_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy got %b want 0", busy); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmc_valid got %b want 0", valid); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmc_done got %b want 0", done); end
    n_tests++; if (sh_cfg !== '0) begin n_fail++; $display("FAIL rmc_shadow_cfg got %h want 0", sh_cfg); end
    n_tests++; if (sh_const !== '0) begin n_fail++; $display("FAIL rmc_shadow_const got %h want 0", sh_const); end
    last_cfg = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rmc_after i%0d got done=%b busy=%b want 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CFG_W-1:0] ec;
    logic [CONST_W-1:0] ek;
    int n_done = 0;
    int cyc = 0;
    int last_done = 0;
    set_pattern(32'h7000_0000, 32'h70);
    for (int i = 0; i < 3; i++) push_expected();
    commit_req = 1'b1;
    pea_idle = 1'b1;
    while (n_done < 3 && cyc < 120) begin
      step();
      cyc++;
      if (done === 1'b1) begin
        n_done++;
        n_tests++;
        if (n_done == 1 && cyc != 17) begin n_fail++; $display("FAIL b2b_first_done got cyc%0d want cyc17", cyc); end
        else if (n_done > 1 && cyc - last_done != 18) begin
          n_fail++; $display("FAIL b2b_interval got %0d want 18", cyc - last_done);
        end
        last_done = cyc;
        if (n_done == 3) commit_req = 1'b0;
        step();
        cyc++;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap n%0d got busy=%b want 0", n_done, busy); end
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid n%0d got %b want 1", n_done, valid); end
        n_tests++;
        if (sb_cfg.size() == 0) begin n_fail++; $display("FAIL b2b_sb_empty n%0d got 0 entries want 1", n_done); end
        else begin
          ec = sb_cfg.pop_front();
          ek = sb_const.pop_front();
          n_tests++; if (sh_cfg !== ec) begin n_fail++; $display("FAIL b2b_cfg n%0d got %h want %h", n_done, sh_cfg, ec); end
          n_tests++; if (sh_const !== ek) begin n_fail++; $display("FAIL b2b_const n%0d got %h want %h", n_done, sh_const, ek); end
        end
      end
    end
    n_tests++;
    if (n_done != 3) begin n_fail++; $display("FAIL b2b_timeout got %0d done pulses want 3", n_done); end
    commit_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got busy=%b want 0", busy); end
`ifdef MAGE_CFG_SHADOW_CNT_EN
    n_tests++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_cnt got %h want 0003", cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_commit_idle();
    test_wait_idle();
    test_write_during_copy();
    test_reset_mid_copy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
